hour_cnt: RTL and testbench
===========================

Name: hour_cnt

Overview:
Hour stage of the clock chain. It sits directly downstream of the minute counter and consumes that counter's one-cycle rollover pulse as its count enable. It keeps the hour of day in 24-hour binary and drives registered BCD digits (12h or 24h format) plus an AM/PM flag to the display mux. It also provides a manual set mode (inc/dec buttons) and a day-rollover pulse for later calendar/alarm stages.

Parameters:
RESET_HOUR, 0, hour loaded on reset, 0..23; any out-of-range value loads 0
CHIME_CYCLES, 4, hour_chime pulse length in clocks (only with HOUR_CHIME_EN), 1..255

Ports:
hour_clk  in  1  system clock
hour_rst_n  in  1  reset, asynchronous, active-low
hour_en  in  1  one-cycle rollover pulse from minute stage
hour_set_en  in  1  level; 1 = manual set mode
hour_inc  in  1  set button, synchronised level; rising edge = +1 hour
hour_dec  in  1  set button, synchronised level; rising edge = -1 hour
hour_mode24  in  1  1 = 24h display, 0 = 12h display
hour_bin  out  5  current hour, binary 0..23
hour_bcd_tens  out  2  display tens digit
hour_bcd_ones  out  4  display ones digit
hour_pm  out  1  1 when hour_bin >= 12
hour_day_out  out  1  one-cycle pulse on 23->0 count rollover
hour_chime  out  1  chime pulse (HOUR_CHIME_EN only; else tied 0)

Behaviour:
- Reset (async assert, sync to clock edge on release): hour_bin=RESET_HOUR; state=RUN; hour_bcd_tens=0, hour_bcd_ones=0, hour_pm=0, hour_day_out=0, hour_chime=0; inc/dec edge-history regs=1.
- Edge-history regs reset to 1, so a button held through reset release gives no edge.
- FSM states: RUN, SET. RUN->SET when hour_set_en=1 is sampled. SET->RUN when hour_set_en=0 is sampled. Transition takes effect the next cycle.
- RUN: hour_en=1 increments hour_bin. At 23, hour_bin goes to 0 and hour_day_out=1 for exactly that cycle (registered on the same edge). Inc/dec edges are ignored.
- SET: hour_en pulses are dropped, not queued. Inc edge: +1, with 23->0. Dec edge: -1, with 0->23. Wraps in SET never assert hour_day_out. Inc and dec edges in the same cycle: no change.
- Cycle where state is changing: the current state's rules apply.
- Edge = current level 1 while previous-cycle level 0; one step per press regardless of hold length.
- Display regs are registered from hour_bin and hour_mode24: 1-cycle latency after any hour_bin or mode change.
  - 24h: tens = h/10, ones = h%10.
  - 12h: v = h%12, with v=0 shown as 12; tens = v/10, ones = v%10.
  - hour_pm = (h>=12) in both modes.
- hour_mode24 toggling never alters hour_bin.
- hour_bin never leaves 0..23.
- Reset asserted mid-set or mid-chime: everything returns to reset values immediately.

Optional Feature:
Macro HOUR_CHIME_EN.
- Defined: every hour_bin increment caused by hour_en in RUN starts a down-counter. hour_chime=1 for CHIME_CYCLES clocks, beginning the cycle after the increment. A new increment during a chime restarts the count. Set-mode changes never chime.
- Undefined: no counter logic; hour_chime tied 0.

Test Plan:
- Reset with RESET_HOUR=0, mode24=1 -> hour_bin=0, digits 0/0, pm=0, day_out=0; button held high through release gives no step.
- RUN from 22, three hour_en pulses -> 23, 0 (day_out=1 one cycle), 1; 12h display at 0 shows tens=1, ones=2, pm=0.
- hour_bin=13, mode24 1->0 -> next cycle tens=0, ones=1, pm=1; hour_bin stays 13.
- SET from 0: one dec edge -> 23 with no day_out; inc held 50 cycles -> exactly one step to 0; inc+dec in same cycle -> unchanged; hour_en pulses ignored.
- Reset pulsed mid-SET at hour 7 -> hour_bin=RESET_HOUR, state RUN, outputs at reset values.
- HOUR_CHIME_EN, CHIME_CYCLES=4: hour_en at 9 -> hour_chime high 4 cycles starting cycle after; second hour_en 2 cycles in -> chime extends to 4 cycles from the restart.

Source files
------------

// File: rtl/hour_cnt_if.sv
// Hour-stage bus: count/set controls in, hour value and display digits out.
interface hour_cnt_if;
    logic       hour_en;
    logic       hour_set_en;
    logic       hour_inc;
    logic       hour_dec;
    logic       hour_mode24;
    logic [4:0] hour_bin;
    logic [1:0] hour_bcd_tens;
    logic [3:0] hour_bcd_ones;
    logic       hour_pm;
    logic       hour_day_out;
    logic       hour_chime;

    modport master (
        output hour_en, hour_set_en, hour_inc, hour_dec, hour_mode24,
        input  hour_bin, hour_bcd_tens, hour_bcd_ones, hour_pm, hour_day_out, hour_chime
    );
    modport slave (
        input  hour_en, hour_set_en, hour_inc, hour_dec, hour_mode24,
        output hour_bin, hour_bcd_tens, hour_bcd_ones, hour_pm, hour_day_out, hour_chime
    );
endinterface

// File: rtl/hour_cnt.sv
// Hour counter (24h binary) with manual set mode, BCD 12h/24h display and day pulse.
// Optional hourly chime pulse built when HOUR_CHIME_EN is defined.
module hour_cnt #(
    parameter int RESET_HOUR   = 0,
    parameter int CHIME_CYCLES = 4
) (
    input  logic     hour_clk,
    input  logic     hour_rst_n,
    hour_cnt_if.slave bus
);
    localparam logic [4:0] RST_H =
        (RESET_HOUR >= 0 && RESET_HOUR <= 23) ? 5'(RESET_HOUR) : 5'd0;

    typedef enum logic {RUN, SET} state_t;

    state_t     state, state_nxt;
    logic [4:0] hour_q, hour_nxt;
    logic       day_q, day_nxt;
    logic       inc_q, dec_q;
    logic       inc_edge, dec_edge;
    logic [4:0] disp_v;
    logic [1:0] tens_c, tens_q;
    logic [3:0] ones_c, ones_q;
    logic       pm_q;

    assign inc_edge = bus.hour_inc & ~inc_q;
    assign dec_edge = bus.hour_dec & ~dec_q;

    always_ff @(posedge hour_clk or negedge hour_rst_n) begin
        if (!hour_rst_n) begin
            state  <= RUN;
            hour_q <= RST_H;
            day_q  <= 1'b0;
            inc_q  <= 1'b1;
            dec_q  <= 1'b1;
            tens_q <= 2'd0;
            ones_q <= 4'd0;
            pm_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            hour_q <= hour_nxt;
            day_q  <= day_nxt;
            inc_q  <= bus.hour_inc;
            dec_q  <= bus.hour_dec;
            tens_q <= tens_c;
            ones_q <= ones_c;
            pm_q   <= (hour_q >= 5'd12);
        end
    end

    // The state being left still governs the cycle in which set_en changes.
    always_comb begin
        state_nxt = state;
        hour_nxt  = hour_q;
        day_nxt   = 1'b0;
        case (state)
            RUN: begin
                if (bus.hour_en) begin
                    if (hour_q == 5'd23) begin
                        hour_nxt = 5'd0;
                        day_nxt  = 1'b1;
                    end else begin
                        hour_nxt = hour_q + 5'd1;
                    end
                end
                if (bus.hour_set_en) state_nxt = SET;
            end
            SET: begin
                if (inc_edge && !dec_edge)
                    hour_nxt = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                else if (dec_edge && !inc_edge)
                    hour_nxt = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
                if (!bus.hour_set_en) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // 12h view maps 0 and 12 to "12".
    always_comb begin
        disp_v = hour_q;
        if (!bus.hour_mode24) begin
            if (hour_q >= 5'd12) disp_v = hour_q - 5'd12;
            if (disp_v == 5'd0)  disp_v = 5'd12;
        end
        if (disp_v >= 5'd20) begin
            tens_c = 2'd2;
            ones_c = 4'(disp_v - 5'd20);
        end else if (disp_v >= 5'd10) begin
            tens_c = 2'd1;
            ones_c = 4'(disp_v - 5'd10);
        end else begin
            tens_c = 2'd0;
            ones_c = disp_v[3:0];
        end
    end

`ifdef HOUR_CHIME_EN
    logic [7:0] chime_cnt;
    logic       chime_start;

    assign chime_start = (state == RUN) && bus.hour_en;

    always_ff @(posedge hour_clk or negedge hour_rst_n) begin
        if (!hour_rst_n)
            chime_cnt <= 8'd0;
        else if (chime_start)
            chime_cnt <= 8'(CHIME_CYCLES);
        else if (chime_cnt != 8'd0)
            chime_cnt <= chime_cnt - 8'd1;
    end

    assign bus.hour_chime = (chime_cnt != 8'd0);
`else
    // CHIME_CYCLES only matters when the chime is built; this term is constant 0.
    assign bus.hour_chime = (CHIME_CYCLES < 0);
`endif

    assign bus.hour_bin      = hour_q;
    assign bus.hour_day_out  = day_q;
    assign bus.hour_bcd_tens = tens_q;
    assign bus.hour_bcd_ones = ones_q;
    assign bus.hour_pm       = pm_q;
endmodule

// File: tb/tb_hour_cnt.sv
// Self-checking bench for hour_cnt: directed scenarios plus randomized traffic vs a model.
module tb_hour_cnt;
    logic hour_clk = 1'b0;
    logic hour_rst_n = 1'b0;
    hour_cnt_if bus ();

    hour_cnt #(.RESET_HOUR(0), .CHIME_CYCLES(4)) dut (
        .hour_clk  (hour_clk),
        .hour_rst_n(hour_rst_n),
        .bus       (bus.slave)
    );

    always #5 hour_clk = ~hour_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, expressed in wall-clock terms.
    int m_hour, m_tens, m_ones, m_left;
    bit m_set, m_day, m_pm, m_inc_prev, m_dec_prev;

    task automatic model_reset();
        m_hour = 0; m_tens = 0; m_ones = 0; m_pm = 0; m_day = 0;
        m_set = 0; m_inc_prev = 1; m_dec_prev = 1; m_left = 0;
    endtask

    // Advance one clock; model reacts to the inputs present at the edge.
    task automatic tick();
        int nh, v, nleft;
        bit nd, ie, de;
        nh = m_hour; nd = 0; nleft = (m_left > 0) ? m_left - 1 : 0;
        ie = bus.hour_inc && !m_inc_prev;
        de = bus.hour_dec && !m_dec_prev;
        if (!m_set) begin
            if (bus.hour_en) begin
                nh = (m_hour + 1) % 24;
                nd = (m_hour == 23);
                nleft = 4;
            end
        end else if (ie != de) begin
            nh = ie ? (m_hour + 1) % 24 : (m_hour + 23) % 24;
        end
        v = bus.hour_mode24 ? m_hour : ((m_hour % 12 == 0) ? 12 : m_hour % 12);
        @(posedge hour_clk);
        #1;
        m_tens = v / 10; m_ones = v % 10; m_pm = (m_hour >= 12);
        m_hour = nh; m_day = nd; m_set = bus.hour_set_en;
        m_inc_prev = bus.hour_inc; m_dec_prev = bus.hour_dec;
`ifdef HOUR_CHIME_EN
        m_left = nleft;
`else
        m_left = 0 * nleft;
`endif
    endtask

    task automatic drive(bit en, bit se, bit inc, bit dec, bit m24);
        bus.hour_en = en; bus.hour_set_en = se; bus.hour_inc = inc;
        bus.hour_dec = dec; bus.hour_mode24 = m24;
    endtask

    task automatic goto_hour(int h);
        drive(0, 1, 0, 0, bus.hour_mode24);
        tick(); tick();
        for (int i = 0; i < 30 && m_hour != h; i++) begin
            bus.hour_inc = 1; tick();
            bus.hour_inc = 0; tick();
        end
        bus.hour_set_en = 0; tick();
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 0, 1);
        hour_rst_n = 0;
        #12 hour_rst_n = 1;
        model_reset();
        @(negedge hour_clk);
        n_cmp++;
        if (bus.hour_bin !== 5'd0 || bus.hour_bcd_tens !== 2'd0 || bus.hour_bcd_ones !== 4'd0 ||
            bus.hour_pm !== 1'b0 || bus.hour_day_out !== 1'b0 || bus.hour_chime !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vals: bin=%0d tens=%0d ones=%0d pm=%0d day=%0d chime=%0d req 0/0/0/0/0/0",
                     bus.hour_bin, bus.hour_bcd_tens, bus.hour_bcd_ones, bus.hour_pm,
                     bus.hour_day_out, bus.hour_chime);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (bus.hour_bin !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_held_btn: bin=%0d req 0", bus.hour_bin);
        end
        drive(0, 0, 0, 0, 1); tick();
    endtask

    task automatic test_run_rollover();
        goto_hour(22);
        bus.hour_en = 1; tick();
        n_cmp++;
        if (bus.hour_bin !== 5'd23 || bus.hour_day_out !== 1'b0) begin
            n_bad++;
            $display("FAIL run_22_23: bin=%0d day=%0d req 23/0", bus.hour_bin, bus.hour_day_out);
        end
        tick();
        n_cmp++;
        if (bus.hour_bin !== 5'd0 || bus.hour_day_out !== 1'b1) begin
            n_bad++;
            $display("FAIL run_23_0: bin=%0d day=%0d req 0/1", bus.hour_bin, bus.hour_day_out);
        end
        bus.hour_en = 0; bus.hour_mode24 = 0; tick();
        n_cmp++;
        if (bus.hour_day_out !== 1'b0 || bus.hour_bcd_tens !== 2'd1 ||
            bus.hour_bcd_ones !== 4'd2 || bus.hour_pm !== 1'b0) begin
            n_bad++;
            $display("FAIL run_12h_zero: day=%0d tens=%0d ones=%0d pm=%0d req 0/1/2/0",
                     bus.hour_day_out, bus.hour_bcd_tens, bus.hour_bcd_ones, bus.hour_pm);
        end
        bus.hour_en = 1; tick(); bus.hour_en = 0;
        n_cmp++;
        if (bus.hour_bin !== 5'd1) begin
            n_bad++;
            $display("FAIL run_0_1: bin=%0d req 1", bus.hour_bin);
        end
    endtask

    task automatic test_mode_switch();
        bus.hour_mode24 = 1;
        goto_hour(13);
        tick();
        bus.hour_mode24 = 0; tick();
        n_cmp++;
        if (bus.hour_bin !== 5'd13 || bus.hour_bcd_tens !== 2'd0 ||
            bus.hour_bcd_ones !== 4'd1 || bus.hour_pm !== 1'b1) begin
            n_bad++;
            $display("FAIL mode_12h_13: bin=%0d tens=%0d ones=%0d pm=%0d req 13/0/1/1",
                     bus.hour_bin, bus.hour_bcd_tens, bus.hour_bcd_ones, bus.hour_pm);
        end
        bus.hour_mode24 = 1; tick();
        n_cmp++;
        if (bus.hour_bcd_tens !== 2'd1 || bus.hour_bcd_ones !== 4'd3) begin
            n_bad++;
            $display("FAIL mode_24h_13: tens=%0d ones=%0d req 1/3", bus.hour_bcd_tens, bus.hour_bcd_ones);
        end
    endtask

    task automatic test_set();
        goto_hour(0);
        bus.hour_set_en = 1; tick(); tick();
        bus.hour_dec = 1; tick(); bus.hour_dec = 0;
        n_cmp++;
        if (bus.hour_bin !== 5'd23 || bus.hour_day_out !== 1'b0) begin
            n_bad++;
            $display("FAIL set_dec_wrap: bin=%0d day=%0d req 23/0", bus.hour_bin, bus.hour_day_out);
        end
        bus.hour_inc = 1;
        for (int i = 0; i < 50; i++) tick();
        bus.hour_inc = 0; tick();
        n_cmp++;
        if (bus.hour_bin !== 5'd0 || bus.hour_day_out !== 1'b0) begin
            n_bad++;
            $display("FAIL set_inc_held: bin=%0d day=%0d req 0/0", bus.hour_bin, bus.hour_day_out);
        end
        bus.hour_inc = 1; bus.hour_dec = 1; tick();
        bus.hour_inc = 0; bus.hour_dec = 0; tick();
        n_cmp++;
        if (bus.hour_bin !== 5'd0) begin
            n_bad++;
            $display("FAIL set_inc_dec: bin=%0d req 0", bus.hour_bin);
        end
        for (int i = 0; i < 4; i++) begin
            bus.hour_en = 1; tick(); bus.hour_en = 0; tick();
        end
        n_cmp++;
        if (bus.hour_bin !== 5'd0) begin
            n_bad++;
            $display("FAIL set_en_drop: bin=%0d req 0", bus.hour_bin);
        end
        bus.hour_set_en = 0; tick();
    endtask

    task automatic test_reset_mid_set();
        goto_hour(7);
        bus.hour_set_en = 1; tick(); tick();
        hour_rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (bus.hour_bin !== 5'd0 || bus.hour_bcd_tens !== 2'd0 || bus.hour_bcd_ones !== 4'd0 ||
            bus.hour_pm !== 1'b0 || bus.hour_day_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_set: bin=%0d tens=%0d ones=%0d pm=%0d day=%0d req 0/0/0/0/0",
                     bus.hour_bin, bus.hour_bcd_tens, bus.hour_bcd_ones, bus.hour_pm, bus.hour_day_out);
        end
        bus.hour_set_en = 0;
        @(negedge hour_clk); hour_rst_n = 1;
        bus.hour_en = 1; tick(); bus.hour_en = 0;
        n_cmp++;
        if (bus.hour_bin !== 5'd1) begin
            n_bad++;
            $display("FAIL rst_state_run: bin=%0d req 1", bus.hour_bin);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0) ? ~bus.hour_set_en : bus.hour_set_en,
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0) ? ~bus.hour_mode24 : bus.hour_mode24);
            tick();
            n_cmp++;
            if (bus.hour_bin !== 5'(m_hour) || bus.hour_day_out !== m_day ||
                bus.hour_bcd_tens !== 2'(m_tens) || bus.hour_bcd_ones !== 4'(m_ones) ||
                bus.hour_pm !== m_pm || bus.hour_chime !== (m_left != 0)) begin
                n_bad++;
                $display("FAIL rand_%0d: bin=%0d/%0d day=%0d/%0d tens=%0d/%0d ones=%0d/%0d pm=%0d/%0d chime=%0d/%0d",
                         i, bus.hour_bin, m_hour, bus.hour_day_out, m_day, bus.hour_bcd_tens, m_tens,
                         bus.hour_bcd_ones, m_ones, bus.hour_pm, m_pm, bus.hour_chime, (m_left != 0));
            end
        end
    endtask

    task automatic test_chime();
        bit exp_c;
        drive(0, 0, 0, 0, 1); tick(); tick();
        goto_hour(9);
        for (int i = 0; i < 10; i++) begin
            bus.hour_en = (i == 0 || i == 2);
            tick();
`ifdef HOUR_CHIME_EN
            exp_c = (i <= 5);
`else
            exp_c = 0;
`endif
            n_cmp++;
            if (bus.hour_chime !== exp_c) begin
                n_bad++;
                $display("FAIL chime_c%0d: chime=%0d req %0d", i, bus.hour_chime, exp_c);
            end
        end
        bus.hour_en = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_rollover();
        test_mode_switch();
        test_set();
        test_reset_mid_set();
        test_chime();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
